// File: rtl/gb_interrupt_dispatcher_if.sv
// Signal bundle between the interrupt dispatcher and the CPU core, register decoder and IRQ lines.
// The dispatcher connects through the slave modport; the CPU side drives the master view.
interface gb_interrupt_dispatcher_if #(
  parameter int NUM_SRC = 5
);
  logic [NUM_SRC-1:0] irq_in;
  logic               ie_we;
  logic               if_we;
  logic [7:0]         bus_wdata;
  logic [7:0]         ie_rdata;
  logic [7:0]         if_rdata;
  logic               ei_req;
  logic               di_req;
  logic               reti_req;
  logic               instr_done;
  logic [15:0]        pc_in;
  logic [15:0]        sp_in;
  logic               mem_we;
  logic [15:0]        mem_addr;
  logic [7:0]         mem_wdata;
  logic               sp_we;
  logic [15:0]        sp_out;
  logic               pc_we;
  logic [15:0]        pc_out;
  logic               busy;
  logic               wake;
  logic               ime;

  modport master (
    output irq_in, ie_we, if_we, bus_wdata, ei_req, di_req, reti_req, instr_done, pc_in, sp_in,
    input  ie_rdata, if_rdata, mem_we, mem_addr, mem_wdata, sp_we, sp_out, pc_we, pc_out,
           busy, wake, ime
  );

  modport slave (
    input  irq_in, ie_we, if_we, bus_wdata, ei_req, di_req, reti_req, instr_done, pc_in, sp_in,
    output ie_rdata, if_rdata, mem_we, mem_addr, mem_wdata, sp_we, sp_out, pc_we, pc_out,
           busy, wake, ime
  );
endinterface

// File: rtl/gb_interrupt_dispatcher.sv
// Game Boy interrupt controller: IE/IF/IME state, priority resolution, HALT wake and the
// five M-cycle dispatch that pushes PC onto the stack and jumps to the selected vector.
module gb_interrupt_dispatcher #(
  parameter logic [15:0] VEC_BASE = 16'h0040,
  parameter int          NUM_SRC  = 5
) (
  input logic                      clk,
  input logic                      rst,
  input logic                      m_tick,
  gb_interrupt_dispatcher_if.slave bus
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [2:0] {IDLE, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP} state_t;

  state_t             state;
  logic [7:0]         ie_q;
  logic [NUM_SRC-1:0] if_q;
  logic [NUM_SRC-1:0] if_next;
  logic [NUM_SRC-1:0] pending;
  logic               ime_q;
  logic               ei_pending;
  logic [15:0]        ret_pc;
  logic [15:0]        base_sp;
  logic               mem_we_q, sp_we_q, pc_we_q;
  logic [15:0]        mem_addr_q, sp_out_q, pc_out_q;
  logic [7:0]         mem_wdata_q;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic [15:0]        vector;

  assign pending = ie_q[NUM_SRC-1:0] & if_q;

  // Scan from the top down so the lowest set bit is the one left standing.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx   = IDX_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

  assign vector = VEC_BASE + {{(13 - IDX_W){1'b0}}, sel_idx, 3'b000};

  // Bus write, then dispatch clear, then new requests, so a same-tick request always survives.
  always_comb begin
    if_next = if_q;
    if (bus.if_we) if_next = bus.bus_wdata[NUM_SRC-1:0];
    if (state == PUSH_LO && sel_valid) if_next[sel_idx] = 1'b0;
    if_next = if_next | bus.irq_in;
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset covers every register, including the datapath outputs, so a reset
    // mid-dispatch can never leave a stale write-back on the bus.
    if (rst) begin
      state       <= IDLE;
      ie_q        <= '0;
      if_q        <= '0;
      ime_q       <= 1'b0;
      ei_pending  <= 1'b0;
      ret_pc      <= '0;
      base_sp     <= '0;
      mem_we_q    <= 1'b0;
      sp_we_q     <= 1'b0;
      pc_we_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sp_out_q    <= '0;
      pc_out_q    <= '0;
    end else if (m_tick) begin
      if (bus.ie_we) ie_q <= bus.bus_wdata;
      if_q     <= if_next;
      mem_we_q <= 1'b0;
      sp_we_q  <= 1'b0;
      pc_we_q  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.reti_req) ime_q <= 1'b1;
          if (bus.ei_req) begin
            ei_pending <= 1'b1;
          end else if (ei_pending && bus.instr_done) begin
            ime_q      <= 1'b1;
            ei_pending <= 1'b0;
          end
          if (bus.instr_done && ime_q && (|pending)) begin
            state   <= WAIT1;
            ime_q   <= 1'b0;
            ret_pc  <= bus.pc_in;
            base_sp <= bus.sp_in;
          end
        end
        WAIT1: state <= WAIT2;
        WAIT2: begin
          state       <= PUSH_HI;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= base_sp - 16'd1;
          mem_wdata_q <= ret_pc[15:8];
        end
        PUSH_HI: begin
          state       <= PUSH_LO;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= base_sp - 16'd2;
          mem_wdata_q <= ret_pc[7:0];
        end
        PUSH_LO: begin
          // Priority is taken now so an IE overwrite by the high-byte push is honoured.
          state    <= JUMP;
          sp_we_q  <= 1'b1;
          sp_out_q <= base_sp - 16'd2;
          pc_we_q  <= 1'b1;
          pc_out_q <= sel_valid ? vector : 16'h0000;
        end
        JUMP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // DI wins over EI, RETI and a maturing EI in the same M-cycle.
      if (bus.di_req) begin
        ime_q      <= 1'b0;
        ei_pending <= 1'b0;
      end
    end
  end

  assign bus.ie_rdata  = ie_q;
  assign bus.if_rdata  = {{(8 - NUM_SRC){1'b1}}, if_q};
  assign bus.mem_we    = mem_we_q & m_tick;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.sp_we     = sp_we_q & m_tick;
  assign bus.sp_out    = sp_out_q;
  assign bus.pc_we     = pc_we_q & m_tick;
  assign bus.pc_out    = pc_out_q;
  assign bus.busy      = (state != IDLE);
  assign bus.wake      = |pending;
  assign bus.ime       = ime_q;
endmodule

// File: tb/tb_gb_interrupt_dispatcher.sv
// Directed bench for the interrupt dispatcher: dispatch timing, priority, EI delay, SP wrap,
// wake, M-cycle gating and reset during a dispatch.
module tb_gb_interrupt_dispatcher;
  logic clk = 1'b0;
  logic rst;
  logic m_tick;
  int   n_tests = 0;
  int   n_fail  = 0;

  gb_interrupt_dispatcher_if bus ();
  gb_interrupt_dispatcher dut (.clk(clk), .rst(rst), .m_tick(m_tick), .bus(bus));

  always #5 clk = ~clk;

  logic [15:0] wr_addr [2];
  logic [7:0]  wr_data [2];
  int          wr_cnt, sp_cnt, pc_cnt, busy_cnt;
  logic [15:0] sp_seen, pc_seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.irq_in = '0; bus.ie_we = 1'b0; bus.if_we = 1'b0; bus.bus_wdata = '0;
    bus.ei_req = 1'b0; bus.di_req = 1'b0; bus.reti_req = 1'b0; bus.instr_done = 1'b0;
    bus.pc_in = '0; bus.sp_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    m_tick = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic prep(input logic [7:0] ie, input logic [7:0] ifv,
                      input logic [15:0] pc, input logic [15:0] sp, input logic ime_on);
    bus.ie_we = 1'b1; bus.bus_wdata = ie;  tick(); bus.ie_we = 1'b0;
    bus.if_we = 1'b1; bus.bus_wdata = ifv; tick(); bus.if_we = 1'b0;
    if (ime_on) begin bus.reti_req = 1'b1; tick(); bus.reti_req = 1'b0; end
    bus.pc_in = pc; bus.sp_in = sp;
  endtask

  // Fires instr_done, then follows the dispatch, echoing 0xFFFF stack writes back as IE writes.
  task automatic run_dispatch(input logic [4:0] irq_mid);
    wr_cnt = 0; sp_cnt = 0; pc_cnt = 0; busy_cnt = 0; sp_seen = '0; pc_seen = '0;
    bus.instr_done = 1'b1; tick(); bus.instr_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!bus.busy) break;
      busy_cnt++;
      bus.irq_in = (k == 0) ? irq_mid : 5'h00;
      if (bus.mem_we) begin
        if (wr_cnt < 2) begin wr_addr[wr_cnt] = bus.mem_addr; wr_data[wr_cnt] = bus.mem_wdata; end
        wr_cnt++;
        if (bus.mem_addr == 16'hFFFF) begin bus.ie_we = 1'b1; bus.bus_wdata = bus.mem_wdata; end
      end
      if (bus.sp_we) begin sp_cnt++; sp_seen = bus.sp_out; end
      if (bus.pc_we) begin pc_cnt++; pc_seen = bus.pc_out; end
      tick();
      bus.ie_we = 1'b0; bus.irq_in = '0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.if_rdata !== 8'hE0) begin n_fail++; $display("FAIL reset_if: got %h expected e0", bus.if_rdata); end
    n_tests++; if (bus.ie_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_ie: got %h expected 00", bus.ie_rdata); end
    n_tests++; if ({bus.busy, bus.ime, bus.wake, bus.mem_we, bus.sp_we, bus.pc_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: busy/ime/wake/mem_we/sp_we/pc_we got %b expected 000000",
                         {bus.busy, bus.ime, bus.wake, bus.mem_we, bus.sp_we, bus.pc_we}); end
    n_tests++; if ({bus.mem_addr, bus.mem_wdata, bus.sp_out, bus.pc_out} !== 56'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.sp_out, bus.pc_out}); end
  endtask

  task automatic test_basic_dispatch();
    do_reset();
    prep(8'h05, 8'h00, 16'h1234, 16'hFFFE, 1'b1);
    bus.irq_in = 5'h01; tick(); bus.irq_in = '0;
    run_dispatch(5'h00);
    n_tests++; if (busy_cnt !== 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 5", busy_cnt); end
    n_tests++; if (wr_cnt !== 2 || sp_cnt !== 1 || pc_cnt !== 1) begin n_fail++;
      $display("FAIL basic_strobe_counts: mem/sp/pc got %0d/%0d/%0d expected 2/1/1", wr_cnt, sp_cnt, pc_cnt); end
    n_tests++; if (wr_addr[0] !== 16'hFFFD || wr_data[0] !== 8'h12) begin n_fail++;
      $display("FAIL basic_push_hi: got %h<=%h expected fffd<=12", wr_addr[0], wr_data[0]); end
    n_tests++; if (wr_addr[1] !== 16'hFFFC || wr_data[1] !== 8'h34) begin n_fail++;
      $display("FAIL basic_push_lo: got %h<=%h expected fffc<=34", wr_addr[1], wr_data[1]); end
    n_tests++; if (sp_seen !== 16'hFFFC) begin n_fail++; $display("FAIL basic_sp: got %h expected fffc", sp_seen); end
    n_tests++; if (pc_seen !== 16'h0040) begin n_fail++; $display("FAIL basic_pc: got %h expected 0040", pc_seen); end
    n_tests++; if (bus.if_rdata !== 8'hE0) begin n_fail++; $display("FAIL basic_if_clear: got %h expected e0", bus.if_rdata); end
    n_tests++; if (bus.ime !== 1'b0) begin n_fail++; $display("FAIL basic_ime: got %b expected 0", bus.ime); end
  endtask

  task automatic test_priority();
    do_reset();
    prep(8'h1C, 8'h1F, 16'h0200, 16'hD000, 1'b1);
    run_dispatch(5'h00);
    n_tests++; if (pc_seen !== 16'h0050) begin n_fail++; $display("FAIL prio_vector: got %h expected 0050", pc_seen); end
    n_tests++; if (bus.if_rdata !== 8'hFB) begin n_fail++; $display("FAIL prio_if: got %h expected fb", bus.if_rdata); end
    n_tests++; if (wr_addr[0] !== 16'hCFFF || wr_data[0] !== 8'h02 || wr_addr[1] !== 16'hCFFE || wr_data[1] !== 8'h00) begin
      n_fail++; $display("FAIL prio_push: got %h<=%h %h<=%h expected cfff<=02 cffe<=00",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]); end
    n_tests++; if (sp_seen !== 16'hCFFE) begin n_fail++; $display("FAIL prio_sp: got %h expected cffe", sp_seen); end
  endtask

  task automatic test_ei_delay();
    do_reset();
    prep(8'h01, 8'h01, 16'h0100, 16'hC000, 1'b0);
    bus.ei_req = 1'b1; bus.instr_done = 1'b1; tick(); bus.ei_req = 1'b0; bus.instr_done = 1'b0;
    n_tests++; if (bus.ime !== 1'b0 || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL ei_at_ei: ime/busy got %b/%b expected 0/0", bus.ime, bus.busy); end
    bus.instr_done = 1'b1; tick(); bus.instr_done = 1'b0;
    n_tests++; if (bus.ime !== 1'b1 || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL ei_next_boundary: ime/busy got %b/%b expected 1/0", bus.ime, bus.busy); end
    run_dispatch(5'h00);
    n_tests++; if (busy_cnt !== 5 || pc_seen !== 16'h0040) begin n_fail++;
      $display("FAIL ei_second_boundary: busy_cycles/pc got %0d/%h expected 5/0040", busy_cnt, pc_seen); end
  endtask

  task automatic test_ei_then_di();
    do_reset();
    prep(8'h01, 8'h01, 16'h0100, 16'hC000, 1'b0);
    bus.ei_req = 1'b1; bus.instr_done = 1'b1; tick(); bus.ei_req = 1'b0;
    bus.di_req = 1'b1; tick(); bus.di_req = 1'b0;
    tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ei_di_busy_a: got %b expected 0", bus.busy); end
    tick(); bus.instr_done = 1'b0;
    n_tests++; if (bus.busy !== 1'b0 || bus.ime !== 1'b0) begin n_fail++;
      $display("FAIL ei_di_final: busy/ime got %b/%b expected 0/0", bus.busy, bus.ime); end
  endtask

  task automatic test_sp_wrap_ie_overwrite();
    do_reset();
    prep(8'h01, 8'h01, 16'h0034, 16'h0000, 1'b1);
    run_dispatch(5'h00);
    n_tests++; if (wr_addr[0] !== 16'hFFFF || wr_data[0] !== 8'h00 || wr_addr[1] !== 16'hFFFE || wr_data[1] !== 8'h34) begin
      n_fail++; $display("FAIL wrap_push: got %h<=%h %h<=%h expected ffff<=00 fffe<=34",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]); end
    n_tests++; if (pc_seen !== 16'h0000 || pc_cnt !== 1) begin n_fail++;
      $display("FAIL wrap_cancel_vector: pc/count got %h/%0d expected 0000/1", pc_seen, pc_cnt); end
    n_tests++; if (sp_seen !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_sp: got %h expected fffe", sp_seen); end
    n_tests++; if (bus.if_rdata !== 8'hE1 || bus.ie_rdata !== 8'h00) begin n_fail++;
      $display("FAIL wrap_if_ie: if/ie got %h/%h expected e1/00", bus.if_rdata, bus.ie_rdata); end
  endtask

  task automatic test_wake_and_if_write();
    do_reset();
    bus.ie_we = 1'b1; bus.bus_wdata = 8'h10; tick(); bus.ie_we = 1'b0;
    bus.irq_in = 5'h10; tick(); bus.irq_in = '0;
    n_tests++; if (bus.wake !== 1'b1 || bus.if_rdata !== 8'hF0 || bus.ime !== 1'b0) begin n_fail++;
      $display("FAIL wake_set: wake/if/ime got %b/%h/%b expected 1/f0/0", bus.wake, bus.if_rdata, bus.ime); end
    bus.instr_done = 1'b1; tick(); bus.instr_done = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wake_no_dispatch: busy got %b expected 0", bus.busy); end
    bus.if_we = 1'b1; bus.bus_wdata = 8'h00; bus.irq_in = 5'h10; tick(); bus.irq_in = '0;
    n_tests++; if (bus.if_rdata !== 8'hF0) begin n_fail++; $display("FAIL if_write_vs_irq: got %h expected f0", bus.if_rdata); end
    tick(); bus.if_we = 1'b0;
    n_tests++; if (bus.if_rdata !== 8'hE0 || bus.wake !== 1'b0 || bus.ie_rdata !== 8'h10) begin n_fail++;
      $display("FAIL if_write_clear: if/wake/ie got %h/%b/%h expected e0/0/10", bus.if_rdata, bus.wake, bus.ie_rdata); end
  endtask

  task automatic test_irq_while_busy();
    do_reset();
    prep(8'h04, 8'h04, 16'h2000, 16'h8000, 1'b1);
    run_dispatch(5'h10);
    n_tests++; if (pc_seen !== 16'h0050 || bus.if_rdata !== 8'hF0) begin n_fail++;
      $display("FAIL busy_irq: pc/if got %h/%h expected 0050/f0", pc_seen, bus.if_rdata); end
  endtask

  task automatic test_m_tick_gate();
    do_reset();
    m_tick = 1'b0;
    bus.irq_in = 5'h01; bus.ie_we = 1'b1; bus.bus_wdata = 8'hFF;
    tick(); tick();
    n_tests++; if (bus.if_rdata !== 8'hE0 || bus.ie_rdata !== 8'h00) begin n_fail++;
      $display("FAIL mtick_gate: if/ie got %h/%h expected e0/00", bus.if_rdata, bus.ie_rdata); end
    idle_inputs();
    m_tick = 1'b1;
  endtask

  task automatic test_reset_mid_dispatch();
    int late_strobes;
    do_reset();
    prep(8'h01, 8'h01, 16'h4321, 16'h9000, 1'b1);
    bus.instr_done = 1'b1; tick(); bus.instr_done = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h8FFE || bus.mem_wdata !== 8'h21) begin n_fail++;
      $display("FAIL midrst_at_push_lo: we/addr/data got %b/%h/%h expected 1/8ffe/21", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++; if ({bus.busy, bus.sp_we, bus.pc_we, bus.mem_we, bus.ime} !== 5'b0 || bus.ie_rdata !== 8'h00 || bus.if_rdata !== 8'hE0) begin
      n_fail++; $display("FAIL midrst_state: busy/sp_we/pc_we/mem_we/ime got %b ie %h if %h expected 00000 00 e0",
                         {bus.busy, bus.sp_we, bus.pc_we, bus.mem_we, bus.ime}, bus.ie_rdata, bus.if_rdata); end
    late_strobes = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.sp_we || bus.pc_we || bus.mem_we) late_strobes++;
      tick();
    end
    n_tests++; if (late_strobes !== 0) begin n_fail++; $display("FAIL midrst_no_writeback: got %0d strobes expected 0", late_strobes); end
  endtask

  initial begin
    test_reset();
    test_basic_dispatch();
    test_priority();
    test_ei_delay();
    test_ei_then_di();
    test_sp_wrap_ie_overwrite();
    test_wake_and_if_write();
    test_irq_while_busy();
    test_m_tick_gate();
    test_reset_mid_dispatch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
